// File: rtl/vmm_out_streamer.sv
// VMM output streamer: serialises each captured result word MSB-first
// onto a valid/ready byte stream and pulses done_o once per element.
module vmm_out_streamer #(
    parameter int DATA_W = 32,
    parameter int ELEMS  = 9
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              next_o,
    input  logic [DATA_W-1:0] data_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic              done_o,
    output logic              busy
);
    localparam int BYTES = DATA_W / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int EW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    localparam logic [BW-1:0] B_LAST = BW'(BYTES - 1);
    localparam logic [EW-1:0] E_LAST = EW'(ELEMS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [EW-1:0]     ecnt_q, ecnt_d;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            S_IDLE: begin
                if (next_o) begin
                    sh_d    = data_in;
                    bcnt_d  = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (bcnt_q == B_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        sh_d   = sh_q << 8;
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                ecnt_d  = (ecnt_q == E_LAST) ? '0 : ecnt_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            bcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    // Every output decodes from registered state only.
    assign out_valid = (state_q == S_SEND);
    assign out_byte  = out_valid ? sh_q[DATA_W-1 -: 8] : 8'h00;
    assign out_last  = out_valid & (bcnt_q == B_LAST) & (ecnt_q == E_LAST);
    assign done_o    = (state_q == S_DONE);
    assign busy      = out_valid | done_o;

endmodule

// File: tb/tb_vmm_out_streamer.sv
// Bench for vmm_out_streamer: scoreboard of expected bytes plus
// per-scenario timing checks.
module tb_vmm_out_streamer;
    localparam int DATA_W = 32;
    localparam int ELEMS  = 3;
    localparam int BYTES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic              next_o = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [7:0]        out_byte;
    logic              out_last;
    logic              done_o;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int elem_n = 0;
    int done_cnt = 0;
    int last_cnt = 0;
    bit sb_en = 1'b1;
    logic [8:0] sb_q[$];
    logic [8:0] sb_e;

    always #5 clk = ~clk;

    vmm_out_streamer #(.DATA_W(DATA_W), .ELEMS(ELEMS)) dut (
        .clk(clk),
        .rst_(rst_),
        .next_o(next_o),
        .data_in(data_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_byte(out_byte),
        .out_last(out_last),
        .done_o(done_o),
        .busy(busy)
    );

    // Scoreboard consumer: one entry per accepted byte.
    always @(negedge clk) begin
        if (sb_en && rst_ && out_valid && out_ready) begin
            checks++;
            if (out_last) last_cnt++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got byte %h, expected no byte", out_byte);
            end else begin
                sb_e = sb_q.pop_front();
                if ({out_last, out_byte} !== sb_e) begin
                    errors++;
                    $display("FAIL sb_byte: got last=%b byte=%h, expected last=%b byte=%h",
                             out_last, out_byte, sb_e[8], sb_e[7:0]);
                end
            end
        end
    end

    task automatic push_elem(input logic [DATA_W-1:0] w);
        for (int k = 0; k < BYTES; k++) begin
            logic lst;
            lst = (k == BYTES - 1) && (elem_n % ELEMS == ELEMS - 1);
            sb_q.push_back({lst, w[DATA_W-1-8*k -: 8]});
        end
        elem_n++;
    endtask

    task automatic send_elem(input logic [DATA_W-1:0] w,
                             input logic [15:0] pat,
                             input int lows);
        int busy_n;
        bit got;
        bit prev_hold;
        logic [7:0] prev_b;
        busy_n = 0;
        got = 1'b0;
        prev_hold = 1'b0;
        prev_b = 8'h00;
        @(posedge clk); #1;
        push_elem(w);
        next_o = 1'b1;
        data_in = w;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk); #1;
            data_in = $urandom;
            out_ready = (c <= 16) ? pat[c-1] : 1'b1;
            @(negedge clk);
            if (busy) busy_n++;
            if (c == 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_byte !== w[DATA_W-1 -: 8]) begin
                    errors++;
                    $display("FAIL first_byte: got v=%b b=%h, expected v=1 b=%h",
                             out_valid, out_byte, w[DATA_W-1 -: 8]);
                end
            end
            if (prev_hold && out_valid) begin
                checks++;
                if (out_byte !== prev_b) begin
                    errors++;
                    $display("FAIL hold_byte: got %h, expected %h", out_byte, prev_b);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_b = out_byte;
            if (done_o) begin
                got = 1'b1;
                done_cnt++;
                checks++;
                if (c != 1 + BYTES + lows) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d, expected %0d", c, 1 + BYTES + lows);
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o, expected one within 40 cycles");
        end
        checks++;
        if (busy_n != BYTES + 1 + lows) begin
            errors++;
            $display("FAIL busy_cycles: got %0d, expected %0d", busy_n, BYTES + 1 + lows);
        end
        @(posedge clk); #1;
        next_o = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_single: got done=%b busy=%b v=%b, expected 0 0 0",
                     done_o, busy, out_valid);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({out_valid, out_byte, out_last, done_o, busy} !== 12'h000) begin
            errors++;
            $display("FAIL %s: got v=%b b=%h l=%b d=%b busy=%b, expected all 0",
                     name, out_valid, out_byte, out_last, done_o, busy);
        end
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_outputs");
        @(posedge clk); #1;
        rst_ = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("idle_outputs");
    endtask

    task automatic test_frame();
        int d0;
        int l0;
        d0 = done_cnt;
        l0 = last_cnt;
        for (int i = 1; i <= 9; i++) send_elem(DATA_W'(i), 16'hFFFF, 0);
        checks++;
        if (done_cnt - d0 != 9) begin
            errors++;
            $display("FAIL frame_done_count: got %0d, expected 9", done_cnt - d0);
        end
        checks++;
        if (last_cnt - l0 != 3) begin
            errors++;
            $display("FAIL frame_last_count: got %0d, expected 3", last_cnt - l0);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL frame_leftover: got %0d bytes pending, expected 0", sb_q.size());
        end
    endtask

    task automatic test_single();
        send_elem(32'hA1B2C3D4, 16'hFFFF, 0);
    endtask

    task automatic test_ready_pattern();
        send_elem(32'hA1B2C3D4, 16'hFF59, 3);
    endtask

    task automatic test_back_to_back();
        int rises;
        int last_rise;
        int bidx;
        int cur_elem;
        bit pv;
        bit stop;
        logic [DATA_W-1:0] prev_d;
        logic [DATA_W-1:0] exp_w;
        logic exp_l;
        rises = 0;
        last_rise = 0;
        bidx = 0;
        cur_elem = 0;
        pv = 1'b0;
        stop = 1'b0;
        exp_w = '0;
        sb_en = 1'b0;
        @(posedge clk); #1;
        next_o = 1'b1;
        out_ready = 1'b1;
        data_in = $urandom;
        for (int c = 1; c <= 60 && !stop; c++) begin
            @(posedge clk); #1;
            prev_d = data_in;
            data_in = $urandom;
            @(negedge clk);
            if (out_valid && !pv) begin
                if (rises > 0) begin
                    checks++;
                    if (c - last_rise < BYTES + 2) begin
                        errors++;
                        $display("FAIL b2b_gap: got %0d, expected >= %0d", c - last_rise, BYTES + 2);
                    end
                end
                rises++;
                last_rise = c;
                exp_w = prev_d;
                bidx = 0;
                cur_elem = elem_n;
                elem_n++;
            end
            if (out_valid) begin
                exp_l = (bidx == BYTES - 1) && (cur_elem % ELEMS == ELEMS - 1);
                checks++;
                if ({out_last, out_byte} !== {exp_l, exp_w[DATA_W-1-8*bidx -: 8]}) begin
                    errors++;
                    $display("FAIL b2b_byte: got last=%b byte=%h, expected last=%b byte=%h",
                             out_last, out_byte, exp_l, exp_w[DATA_W-1-8*bidx -: 8]);
                end
                bidx++;
            end
            if (done_o) done_cnt++;
            if (done_o && rises == 4) stop = 1'b1;
            pv = out_valid;
        end
        @(posedge clk); #1;
        next_o = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rises != 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: got %0d captures busy=%b, expected 4 busy=0", rises, busy);
        end
        sb_en = 1'b1;
    endtask

    task automatic test_mid_reset();
        int d0;
        int l0;
        @(posedge clk); #1;
        next_o = 1'b1;
        data_in = 32'hDEADBEEF;
        out_ready = 1'b1;
        push_elem(32'hDEADBEEF);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'hBE) begin
            errors++;
            $display("FAIL mid_byte2: got v=%b b=%h, expected v=1 b=be", out_valid, out_byte);
        end
        d0 = done_cnt;
        #2;
        rst_ = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        sb_q.delete();
        elem_n = 0;
        next_o = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_hold");
        @(posedge clk); #1;
        rst_ = 1'b1;
        l0 = last_cnt;
        send_elem(32'h01020304, 16'hFFFF, 0);
        for (int i = 1; i < ELEMS; i++) send_elem(32'h11223344 + DATA_W'(i), 16'hFFFF, 0);
        checks++;
        if (last_cnt - l0 != 1 || done_cnt - d0 != ELEMS) begin
            errors++;
            $display("FAIL reset_frame: got last=%0d done=%0d, expected last=1 done=%0d",
                     last_cnt - l0, done_cnt - d0, ELEMS);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL reset_leftover: got %0d bytes pending, expected 0", sb_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_single();
        test_ready_pattern();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
